alu_multicycle: RTL and testbench

//  Parametrised successor to the MIPS datapath single-cycle ALU. Extends the op set with xor, nor and shifts,
//  and adds iterative unsigned multiply and divide. All results are registered behind a start/done handshake.

---
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply and divide,
// all results registered and presented with a one-cycle done pulse.
module alu_multicycle #(
    parameter int WIDTH     = 16,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] work_hi_reg;
    logic [WIDTH-1:0] work_lo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             is_div_reg;
    logic [CNT_W-1:0] count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             zero_reg;
    logic             dbz_reg;

    logic             accept;
    logic             is_mul_op;
    logic             is_div_op;
    logic [WIDTH-1:0] single_res;

    assign accept    = start && (state_reg != ST_BUSY);
    assign is_mul_op = MULDIV_EN && (alu_control == OP_MULU);
    assign is_div_op = MULDIV_EN && (alu_control == OP_DIVU);

    always_comb begin
        single_res = a + b;
        case (alu_control)
            OP_SUB:  single_res = a - b;
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  single_res = a ^ b;
            OP_NOR:  single_res = ~(a | b);
            OP_SLL:  single_res = a << b[SH_W-1:0];
            OP_SRL:  single_res = a >> b[SH_W-1:0];
            default: single_res = a + b;
        endcase
    end

    // Multiply: {work_hi, work_lo} is the product register, multiplier consumed from work_lo[0].
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, divisor_reg} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};

    // Restoring divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    // A zero divisor always "fits", which yields quotient all ones and remainder equal to the dividend.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign div_shift   = {work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_ge      = div_shift >= {1'b0, divisor_reg};
    assign div_diff    = div_shift - {1'b0, divisor_reg};
    assign div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {work_lo_reg[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign step_hi = is_div_reg ? div_hi_next : mul_hi_next;
    assign step_lo = is_div_reg ? div_lo_next : mul_lo_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            work_hi_reg   <= '0;
            work_lo_reg   <= '0;
            divisor_reg   <= '0;
            is_div_reg    <= 1'b0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b1;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            if (is_mul_op || is_div_op) begin
                state_reg   <= ST_BUSY;
                busy_reg    <= 1'b1;
                done_reg    <= 1'b0;
                work_hi_reg <= '0;
                work_lo_reg <= a;
                divisor_reg <= b;
                is_div_reg  <= is_div_op;
                count_reg   <= CNT_W'(WIDTH);
            end else begin
                state_reg     <= ST_DONE;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
                result_reg    <= single_res;
                result_hi_reg <= '0;
                zero_reg      <= (single_res == '0);
                dbz_reg       <= 1'b0;
            end
        end else if (state_reg == ST_BUSY) begin
            work_hi_reg <= step_hi;
            work_lo_reg <= step_lo;
            count_reg   <= count_reg - 1'b1;
            if (count_reg == CNT_W'(1)) begin
                state_reg     <= ST_DONE;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
                result_reg    <= step_lo;
                result_hi_reg <= step_hi;
                zero_reg      <= (step_lo == '0);
                dbz_reg       <= is_div_reg && (divisor_reg == '0);
            end
        end else begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign result_hi   = result_hi_reg;
    assign zero        = zero_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: cycle-level reference model with per-cycle comparison,
// directed literal cases, and randomized ops including ignored mid-op starts.
module tb_alu_multicycle;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_control;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .alu_control(alu_control), .busy(busy), .done(done),
        .result(result), .result_hi(result_hi), .zero(zero),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic [W-1:0] h, output bit d);
        logic [31:0] p;
        r = '0; h = '0; d = 1'b0;
        case (op)
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = (x < y) ? 16'd1 : 16'd0;
            4'd5:  r = x ^ y;
            4'd6:  r = ~(x | y);
            4'd7:  r = x << y[3:0];
            4'd8:  r = x >> y[3:0];
            4'd9:  begin p = {16'd0, x} * {16'd0, y}; r = p[15:0]; h = p[31:16]; end
            4'd10: begin
                if (y == 0) begin r = 16'hFFFF; h = x; d = 1'b1; end
                else begin r = x / y; h = x % y; end
            end
            default: r = x + y;
        endcase
    endfunction

    // Reference model: tracks remaining latency and expected visible outputs.
    bit           m_valid = 1'b0;
    int           m_left = 0;
    bit           m_busy, m_done, m_zero, m_dbz;
    logic [W-1:0] m_res, m_hi, p_res, p_hi;
    bit           p_dbz;

    always @(posedge clk) begin
        logic [W-1:0] r, h;
        bit d;
        if (reset) begin
            m_valid = 1'b1;
            m_left = 0;
            m_done = 1'b0; m_res = '0; m_hi = '0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = p_res; m_hi = p_hi; m_dbz = p_dbz; m_done = 1'b1;
                end
            end else if (start) begin
                model_op(alu_control, a, b, r, h, d);
                if (alu_control == 4'd9 || alu_control == 4'd10) begin
                    p_res = r; p_hi = h; p_dbz = d; m_left = W;
                end else begin
                    m_res = r; m_hi = h; m_dbz = d; m_done = 1'b1;
                end
            end
        end
        m_busy = (m_left > 0);
        m_zero = (m_res == 0);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("result", {16'd0, result}, {16'd0, m_res});
            check("result_hi", {16'd0, result_hi}, {16'd0, m_hi});
            check("zero", {31'd0, zero}, {31'd0, m_zero});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    // Issues one op at a negedge, returns at the negedge where done is seen.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input bit poke, output int lat);
        start = 1'b1; alu_control = op; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (poke && busy === 1'b1) begin
                start = 1'($urandom_range(0, 1));
                alu_control = 4'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [3:0] op;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b1; alu_control = 4'd0; a = 16'd1; b = 16'd1;
        repeat (2) @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);

        // back-to-back single-cycle ops
        start = 1'b1; alu_control = 4'd0; a = 16'hFFFF; b = 16'h0001;
        @(negedge clk);
        check("add_wrap_done", {31'd0, done}, 32'd1);
        check("add_wrap_res", {16'd0, result}, 32'h0);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        alu_control = 4'd1; a = 16'd5; b = 16'd5;
        @(negedge clk);
        check("sub_done", {31'd0, done}, 32'd1);
        check("sub_res", {16'd0, result}, 32'h0);
        alu_control = 4'd4; a = 16'd3; b = 16'd7;
        @(negedge clk);
        check("slt_done", {31'd0, done}, 32'd1);
        check("slt_res", {16'd0, result}, 32'h1);
        check("slt_zero", {31'd0, zero}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);

        run_op(4'd7, 16'h0001, 16'h000F, 1'b0, lat);
        check("sll_res", {16'd0, result}, 32'h8000);
        run_op(4'd8, 16'h8000, 16'h0013, 1'b0, lat);
        check("srl_res", {16'd0, result}, 32'h1000);
        check("srl_lat", lat, 32'd1);

        // mulu with a start pulse in the middle that must be ignored
        start = 1'b1; alu_control = 4'd9; a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 5) begin start = 1'b1; alu_control = 4'd0; a = 16'd9; b = 16'd9; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("mul_lat", lat, 32'd17);
        check("mul_res", {16'd0, result}, 32'h0001);
        check("mul_hi", {16'd0, result_hi}, 32'hFFFE);
        check("mul_busy_at_done", {31'd0, busy}, 32'd0);

        run_op(4'd10, 16'd100, 16'd7, 1'b0, lat);
        check("div_res", {16'd0, result}, 32'd14);
        check("div_rem", {16'd0, result_hi}, 32'd2);
        run_op(4'd10, 16'h1234, 16'h0000, 1'b0, lat);
        check("div0_res", {16'd0, result}, 32'hFFFF);
        check("div0_hi", {16'd0, result_hi}, 32'h1234);
        check("div0_flag", {31'd0, div_by_zero}, 32'd1);
        check("div0_lat", lat, 32'd17);

        // reset in the middle of a multiply
        start = 1'b1; alu_control = 4'd9; a = 16'h0123; b = 16'h0456;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_hi", {16'd0, result_hi}, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd1);
        repeat (20) @(negedge clk);
        check("abort_no_done", {31'd0, done}, 32'd0);
        run_op(4'd0, 16'd2, 16'd2, 1'b0, lat);
        check("post_abort_add", {16'd0, result}, 32'd4);
        check("post_abort_lat", lat, 32'd1);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 16'h00FF;
            run_op(op, ra, rb, 1'b1, lat);
            check("rand_lat", lat, (op == 4'd9 || op == 4'd10) ? 32'd17 : 32'd1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
